// File: rtl/serial_add_sched.sv
// Four-requester scheduler sharing one bit-serial full adder; results go out on a CDB.
// Optional subtract mode (A + ~B + 1 per requester) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_sched #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   a_i,
    input  logic [4*WIDTH-1:0]   b_i,
    input  logic [4*TAG_W-1:0]   tag_i,
`ifdef SERIAL_ADD_SUB_EN
    input  logic [3:0]           sub_i,
`endif
    output logic [3:0]           gnt,
    output logic                 busy,
    output logic                 cdb_valid,
    output logic [TAG_W-1:0]     cdb_tag,
    output logic [WIDTH-1:0]     cdb_data,
    output logic                 cdb_carry,
    input  logic                 cdb_ack,
    output logic [1:0]           o_dbg_state
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [1:0]         r_rr_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_sub;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic [TAG_W-1:0]   r_tag;

    logic [1:0]         w_sel;
    logic               w_any;
    logic               w_sub_sel;
    logic               w_a_bit;
    logic               w_b_bit;
    logic               w_sum;
    logic               w_cout;

    // Round-robin scan from r_rr_ptr upward; iterating from the farthest offset
    // down leaves the nearest requesting index in w_sel.
    always_comb begin
        w_sel = r_rr_ptr;
        w_any = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_rr_ptr + 2'(k)]) begin
                w_sel = r_rr_ptr + 2'(k);
                w_any = 1'b1;
            end
        end
    end

`ifdef SERIAL_ADD_SUB_EN
    assign w_sub_sel = sub_i[w_sel];
`else
    assign w_sub_sel = 1'b0;
`endif

    // Subtraction inverts B bit by bit; the +1 comes from the preset carry.
    assign w_a_bit = r_a[r_cnt];
    assign w_b_bit = r_b[r_cnt] ^ r_sub;
    assign w_sum   = w_a_bit ^ w_b_bit ^ r_carry;
    assign w_cout  = (w_a_bit & w_b_bit) | (w_a_bit & r_carry) | (w_b_bit & r_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= 2'd0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_sub    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_tag    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a      <= a_i[w_sel*WIDTH +: WIDTH];
                        r_b      <= b_i[w_sel*WIDTH +: WIDTH];
                        r_tag    <= tag_i[w_sel*TAG_W +: TAG_W];
                        r_sub    <= w_sub_sel;
                        r_carry  <= w_sub_sel;
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_rr_ptr <= w_sel + 2'd1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result[r_cnt] <= w_sum;
                    r_carry         <= w_cout;
                    r_cnt           <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (cdb_ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // rst_n gates the grant so it is low for the whole reset window.
    assign gnt         = (rst_n && (r_state == S_IDLE) && w_any) ? (4'b0001 << w_sel) : 4'b0000;
    assign busy        = (r_state != S_IDLE);
    assign cdb_valid   = (r_state == S_DONE);
    assign cdb_tag     = cdb_valid ? r_tag    : '0;
    assign cdb_data    = cdb_valid ? r_result : '0;
    assign cdb_carry   = cdb_valid ? r_carry  : 1'b0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched: directed scenarios plus random traffic, all checked by
// a transaction-level model (round-robin pointer, arithmetic result, cycle latency).
module tb_serial_add_sched;
    localparam int WIDTH = 8;
    localparam int TAG_W = 3;
    localparam int W     = TAG_W + WIDTH + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [3:0]           req = '0;
    logic [4*WIDTH-1:0]   a_i = '0;
    logic [4*WIDTH-1:0]   b_i = '0;
    logic [4*TAG_W-1:0]   tag_i = '0;
    logic                 cdb_ack = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    logic [3:0]           sub_i = '0;
`endif
    logic [3:0]           gnt;
    logic                 busy;
    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;
    logic [WIDTH-1:0]     cdb_data;
    logic                 cdb_carry;
    logic [1:0]           o_dbg_state;

    serial_add_sched #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_i(a_i), .b_i(b_i), .tag_i(tag_i),
`ifdef SERIAL_ADD_SUB_EN
        .sub_i(sub_i),
`endif
        .gnt(gnt), .busy(busy), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_carry(cdb_carry), .cdb_ack(cdb_ack),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [W-1:0] exp_q[$];
    int          gnt_log[$];
    int          gnt_cyc[$];
    logic        model_busy = 1'b0;
    int          model_ptr = 0;
    int          exp_vcyc = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: plain integer add (or add of two's complement) on WIDTH+1 bits.
    function automatic logic [W-1:0] ref_result(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                                logic [TAG_W-1:0] tag, logic sub);
        int unsigned s;
        int unsigned mask;
        mask = (1 << WIDTH) - 1;
        if (sub) s = int'(a) + ((~int'(b)) & mask) + 1;
        else     s = int'(a) + int'(b);
        return {tag, s[WIDTH], s[WIDTH-1:0]};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic       exp_valid;
        int         sel;
        logic [3:0] exp_gnt;
        logic       s;
        if (!rst_n) begin
            check("reset_outputs", {gnt, busy, cdb_valid, cdb_tag, cdb_data, cdb_carry}, '0);
            model_busy = 1'b0;
            model_ptr  = 0;
            exp_q.delete();
        end else begin
            exp_valid = model_busy && (cyc >= exp_vcyc);
            check("cdb_valid", cdb_valid, exp_valid);
            check("busy", busy, model_busy);
            if (cdb_valid) begin
                if (exp_q.size() > 0) check("cdb_result", {cdb_tag, cdb_carry, cdb_data}, exp_q[0]);
                else check("cdb_unexpected", cdb_valid, 1'b0);
            end else begin
                check("cdb_idle_zero", {cdb_tag, cdb_carry, cdb_data}, '0);
            end

            sel = -1;
            if (!model_busy) begin
                for (int k = 0; k < 4; k++) begin
                    if (sel < 0 && req[(model_ptr + k) % 4]) sel = (model_ptr + k) % 4;
                end
            end
            exp_gnt = (sel >= 0) ? 4'(1 << sel) : 4'b0000;
            check("gnt", gnt, exp_gnt);
            for (int i = 0; i < 4; i++) begin
                if (gnt[i]) begin
                    gnt_log.push_back(i);
                    gnt_cyc.push_back(cyc);
                end
            end
            if (sel >= 0) begin
`ifdef SERIAL_ADD_SUB_EN
                s = sub_i[sel];
`else
                s = 1'b0;
`endif
                exp_q.push_back(ref_result(a_i[sel*WIDTH +: WIDTH], b_i[sel*WIDTH +: WIDTH],
                                           tag_i[sel*TAG_W +: TAG_W], s));
                model_busy = 1'b1;
                model_ptr  = (sel + 1) % 4;
                exp_vcyc   = cyc + WIDTH + 1;
            end

            if (cdb_valid && cdb_ack && model_busy) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                model_busy = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        cdb_ack = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [TAG_W-1:0] t);
        a_i[i*WIDTH +: WIDTH]   = a;
        b_i[i*TAG_W*0 + i*WIDTH +: WIDTH] = b;
        tag_i[i*TAG_W +: TAG_W] = t;
    endtask

    task automatic rand_ops();
        a_i   = {$urandom, $urandom};
        b_i   = {$urandom, $urandom};
        tag_i = 12'($urandom);
`ifdef SERIAL_ADD_SUB_EN
        sub_i = 4'($urandom);
`endif
    endtask

    task automatic single_op(input string name, input int i, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t,
                             input logic [WIDTH-1:0] exp_d, input logic exp_c);
        set_op(i, a, b, t);
        req = 4'(1 << i);
        #1;
        check({name, "_gnt"}, gnt, 4'(1 << i));
        step();
        req = '0;
        repeat (WIDTH) step();
        check({name, "_valid"}, cdb_valid, 1'b1);
        check({name, "_data"}, cdb_data, exp_d);
        check({name, "_carry"}, cdb_carry, exp_c);
        check({name, "_tag"}, cdb_tag, t);
        cdb_ack = 1'b1;
        step();
        cdb_ack = 1'b0;
        check({name, "_idle"}, busy, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
`ifdef SERIAL_ADD_SUB_EN
        sub_i = '0;
`endif
        single_op("add_5a_3c", 0, 8'h5A, 8'h3C, 3'd5, 8'h96, 1'b0);
        do_reset();
        single_op("add_ff_01", 2, 8'hFF, 8'h01, 3'd7, 8'h00, 1'b1);

        // Round-robin order with all four requesting and immediate acks.
        do_reset();
        rand_ops();
`ifdef SERIAL_ADD_SUB_EN
        sub_i = '0;
`endif
        gnt_log.delete();
        gnt_cyc.delete();
        cdb_ack = 1'b1;
        req = 4'b1111;
        repeat (41) step();
        req = '0;
        repeat (12) step();
        cdb_ack = 1'b0;
        check("rr_count", gnt_log.size(), 5);
        if (gnt_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("rr_order", gnt_log[i], i % 4);
            for (int i = 1; i < 5; i++) check("rr_spacing", gnt_cyc[i] - gnt_cyc[i-1], 10);
        end

        // Hold result in DONE while the CDB stalls; req stays high and must be ignored.
        do_reset();
        set_op(3, 8'h12, 8'h34, 3'd2);
        req = 4'b1000;
        step();
        repeat (WIDTH) step();
        check("hold_valid0", cdb_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", cdb_valid, 1'b1);
            check("hold_data", cdb_data, 8'h46);
            check("hold_gnt", gnt, 4'b0000);
        end
        cdb_ack = 1'b1;
        step();
        cdb_ack = 1'b0;
        check("hold_release_busy", busy, 1'b0);
        check("hold_regrant", gnt, 4'b1000);
        req = '0;
        repeat (WIDTH + 2) step();
        cdb_ack = 1'b1;
        step();
        cdb_ack = 1'b0;

        // Reset in the middle of RUN drops the operation; pointer returns to 0.
        do_reset();
        set_op(1, 8'hA5, 8'h11, 3'd3);
        req = 4'b0010;
        step();
        req = '0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {gnt, busy, cdb_valid, cdb_tag, cdb_data, cdb_carry}, '0);
        step();
        step();
        rst_n = 1'b1;
        req = 4'b1111;
        #1;
        check("midrst_first_gnt", gnt, 4'b0001);
        step();
        req = '0;
        cdb_ack = 1'b1;
        repeat (WIDTH + 3) step();
        cdb_ack = 1'b0;

`ifdef SERIAL_ADD_SUB_EN
        do_reset();
        sub_i = 4'b1111;
        single_op("sub_10_01", 0, 8'h10, 8'h01, 3'd1, 8'h0F, 1'b1);
        single_op("sub_01_02", 1, 8'h01, 8'h02, 3'd4, 8'hFF, 1'b0);
`endif

        // Random traffic with random acks and occasional asynchronous resets.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rand_ops();
            req     = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            cdb_ack = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
            step();
            rst_n = 1'b1;
        end
        req     = '0;
        cdb_ack = 1'b1;
        repeat (WIDTH + 4) step();
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
